// File: rtl/ps2_pkg.sv
// ps2_pkg -- definitions shared by the PS/2 host transmit and receive sides.
//   ps2_state_e       : host-to-device transmit state encoding
//   PS2_*             : default timing constants in 7 MHz clock-enable ticks
//   ps2_max3()        : largest of three values, used to size the shared timer
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam int PS2_INHIBIT_TICKS  = 784;     // 112 us clock inhibit
    localparam int PS2_START_TIMEOUT  = 105000;  // 15 ms until first device clock
    localparam int PS2_XFER_TIMEOUT   = 14000;   // 2 ms from first clock to ACK

    function automatic int ps2_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// ps2_sync -- brings the asynchronous PS/2 clock and data lines into clk_sys
// and detects falling edges of the synchronized clock line.
//   clk_sys  : system clock
//   reset    : synchronous active-high reset (synchronizers reset to 1 = idle bus)
//   ps2_clk  : raw PS/2 clock line
//   ps2_data : raw PS/2 data line
//   clk_s    : synchronized clock line
//   data_s   : synchronized data line
//   clk_fall : one-cycle strobe on a high-to-low transition of clk_s
module ps2_sync
    import ps2_pkg::*;
(
    input  logic clk_sys,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_s,
    output logic data_s,
    output logic clk_fall
);

    logic [1:0] raw_w;
    logic [1:0] sync_w;
    logic       clk_prev_q;

    assign raw_w = {ps2_data, ps2_clk};

    // Two-flop synchronizer per line; index 0 = clock, 1 = data.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_q;
            logic sync_q;
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    meta_q <= 1'b1;
                    sync_q <= 1'b1;
                end else begin
                    meta_q <= raw_w[gi];
                    sync_q <= meta_q;
                end
            end
            assign sync_w[gi] = sync_q;
        end
    endgenerate

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= sync_w[0];
        end
    end

    assign clk_s    = sync_w[0];
    assign data_s   = sync_w[1];
    assign clk_fall = clk_prev_q & ~sync_w[0];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- sends one command byte from host to a PS/2 device.
//   clk_sys / reset         : system clock, synchronous active-high reset
//   ce_7mp                  : 7 MHz enable, timebase of every timer
//   ps2_mouse_clk/_data     : sensed bus lines (asynchronous)
//   ps2_clk_oe/ps2_data_oe  : 1 = pull the line low, 0 = release
//   tx_data / tx_start      : byte and one-cycle request (accepted only in IDLE)
//   busy                    : high from accepted request until back in IDLE
//   done / error            : one-cycle result pulses (ACK / missing ACK or timeout)
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_TICKS = PS2_INHIBIT_TICKS,
    parameter int START_TIMEOUT = PS2_START_TIMEOUT,
    parameter int XFER_TIMEOUT  = PS2_XFER_TIMEOUT
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce_7mp,
    input  logic       ps2_mouse_clk,
    input  logic       ps2_mouse_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int TIMER_MAX = ps2_max3(INHIBIT_TICKS, START_TIMEOUT, XFER_TIMEOUT);
    localparam int TW        = $clog2(TIMER_MAX + 1);

    localparam logic [TW-1:0] INHIBIT_LIM = TW'(INHIBIT_TICKS);
    localparam logic [TW-1:0] START_LIM   = TW'(START_TIMEOUT);
    localparam logic [TW-1:0] XFER_LIM    = TW'(XFER_TIMEOUT);

    logic clk_s, data_s, clk_fall;

    ps2_sync u_sync (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_mouse_clk),
        .ps2_data (ps2_mouse_data),
        .clk_s    (clk_s),
        .data_s   (data_s),
        .clk_fall (clk_fall)
    );

    ps2_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [8:0]    frame_q, frame_d;     // {parity, data}
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic [TW-1:0] timer_lim;
    logic          timed;
    logic          tick_up;
    logic          last_tick;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // The one timer is reused per state against that state's limit.
    always_comb begin
        timer_lim = '0;
        timed     = 1'b1;
        case (state_q)
            INHIBIT:    timer_lim = INHIBIT_LIM;
            REQUEST:    timer_lim = START_LIM;
            SHIFT, ACK: timer_lim = XFER_LIM;
            default:    timed     = 1'b0;
        endcase
    end

    assign tick_up   = timed && ce_7mp && (timer_q != timer_lim);
    // Acting on the tick that reaches the limit makes the reaction land
    // exactly N ticks after the timer was cleared.
    assign last_tick = tick_up && ((timer_q + TW'(1)) == timer_lim);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        if (tick_up) begin
            timer_d = timer_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (tx_start) begin
                    frame_d  = {~^tx_data, tx_data};
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                // Start bit goes down first; the clock is released one cycle later.
                if (data_oe_q) begin
                    clk_oe_d = 1'b0;
                    timer_d  = '0;
                    state_d  = REQUEST;
                end else if (last_tick || timer_q == INHIBIT_LIM) begin
                    data_oe_d = 1'b1;
                end
            end
            REQUEST: begin
                if (last_tick) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    error_d   = 1'b1;
                    state_d   = WAIT_IDLE;
                end else if (clk_fall) begin
                    data_oe_d = ~frame_q[0];
                    bit_cnt_d = 4'd1;
                    timer_d   = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (last_tick) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    error_d   = 1'b1;
                    state_d   = WAIT_IDLE;
                end else if (clk_fall) begin
                    if (bit_cnt_q == 4'd9) begin
                        data_oe_d = 1'b0;        // stop bit: release data
                        state_d   = ACK;
                    end else begin
                        data_oe_d = ~frame_q[bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ACK: begin
                if (last_tick) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    error_d   = 1'b1;
                    state_d   = WAIT_IDLE;
                end else if (clk_fall) begin
                    done_d  = ~data_s;
                    error_d = data_s;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                timer_d   = '0;
                if (clk_s && data_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH  = 25;
    localparam int STO  = 300;
    localparam int XTO  = 400;
    localparam int HALF = 12;

    logic       clk_sys  = 1'b0;
    logic       reset    = 1'b1;
    logic       ce_7mp   = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, error;
    logic       clk_line, data_line;

    // Open-drain bus: either side may pull low.
    assign clk_line  = dev_clk & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_TICKS (INH),
        .START_TIMEOUT (STO),
        .XFER_TIMEOUT  (XTO)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ce_7mp         (ce_7mp),
        .ps2_mouse_clk  (clk_line),
        .ps2_mouse_data (data_line),
        .ps2_clk_oe     (ps2_clk_oe),
        .ps2_data_oe    (ps2_data_oe),
        .tx_data        (tx_data),
        .tx_start       (tx_start),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        #1;
        ce_7mp = ($urandom_range(0, 3) != 0);
    end

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int both_cnt    = 0;

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (error) err_cnt++;
            if (done && error) both_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        @(posedge clk_sys);
        #1;
        tx_start = 1'b0;
    endtask

    // Device side: generates nfalls clock pulses, samples data on each rising
    // edge, optionally ACKs on the 11th pulse and injects a stray tx_start.
    task automatic dev_frame(input int nfalls, input bit ack, input int poke_fall,
                             input logic [7:0] poke_data, output logic [10:0] smp);
        smp = '0;
        @(negedge clk_sys);
        smp[0] = data_line;
        cyc(2);
        for (int k = 1; k <= nfalls; k++) begin
            if (k == 11) begin
                dev_data = ~ack;
                cyc(HALF);
            end
            dev_clk = 1'b0;
            if (k == poke_fall) begin
                tx_data  = poke_data;
                tx_start = 1'b1;
                cyc(1);
                tx_start = 1'b0;
                cyc(HALF - 1);
            end else begin
                cyc(HALF);
            end
            dev_clk = 1'b1;
            @(negedge clk_sys);
            if (k <= 10) smp[k] = data_line;
            cyc(HALF);
            if (k == 11) dev_data = 1'b1;
        end
    endtask

    // Waits for REQUEST entry (clock released after inhibit); returns at that negedge.
    task automatic wait_request(input string name);
        int guard = 0;
        do begin
            @(negedge clk_sys);
            guard++;
        end while (ps2_clk_oe && guard < 5000);
        vectors++;
        if (ps2_clk_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_request: clk_oe got %b expected 0 within bound", name, ps2_clk_oe);
        end
    endtask

    task automatic wait_not_busy(input string name);
        int guard = 0;
        while (busy && guard < 3000) begin
            @(negedge clk_sys);
            guard++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_busy_drop: busy got %b expected 0 within bound", name, busy);
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input int poke_fall,
                             input bit poke_inhibit, input string name);
        int d0 = done_cnt;
        int e0 = err_cnt;
        int ticks = 0;
        int guard = 0;
        logic [10:0] smp;
        logic [10:0] exp_bits;

        // Reference frame: start 0, data LSB first, odd parity, stop 1.
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = ((d >> i) & 8'd1) != 0;
        exp_bits[9]  = ($countones(d) % 2) == 0;
        exp_bits[10] = 1'b1;

        pulse_start(d);
        while (guard < 5000) begin
            @(negedge clk_sys);
            if (ps2_data_oe) break;
            if (poke_inhibit && guard == 5) begin
                tx_data  = ~d;
                tx_start = 1'b1;
            end else begin
                tx_start = 1'b0;
            end
            if (ps2_clk_oe && ce_7mp) ticks++;
            guard++;
        end
        tx_start = 1'b0;
        vectors++;
        if (ticks !== INH) begin
            miscompares++;
            $display("FAIL %s_inhibit_ticks: got %0d expected %0d", name, ticks, INH);
        end
        vectors++;
        if (ps2_clk_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_clk_held_at_start_bit: clk_oe got %b expected 1", name, ps2_clk_oe);
        end
        wait_request(name);
        vectors++;
        if (ps2_data_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_start_bit: data_oe got %b expected 1", name, ps2_data_oe);
        end
        dev_frame(11, ack, poke_fall, ~d, smp);
        vectors++;
        if (smp !== exp_bits) begin
            miscompares++;
            $display("FAIL %s_frame_bits: got %b expected %b", name, smp, exp_bits);
        end
        wait_not_busy(name);
        vectors++;
        if ((done_cnt - d0) !== (ack ? 1 : 0)) begin
            miscompares++;
            $display("FAIL %s_done_count: got %0d expected %0d", name, done_cnt - d0, ack ? 1 : 0);
        end
        vectors++;
        if ((err_cnt - e0) !== (ack ? 0 : 1)) begin
            miscompares++;
            $display("FAIL %s_error_count: got %0d expected %0d", name, err_cnt - e0, ack ? 0 : 1);
        end
        vectors++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            miscompares++;
            $display("FAIL %s_lines_released: oe got %b expected 00", name, {ps2_clk_oe, ps2_data_oe});
        end
        $display("tx %s data=%02h ack=%0d bits=%b inhibit_ticks=%0d", name, d, ack, smp, ticks);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(5);
        @(negedge clk_sys);
        vectors++;
        if ({ps2_clk_oe, ps2_data_oe, busy, done, error} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {ps2_clk_oe, ps2_data_oe, busy, done, error});
        end
        reset = 1'b0;
        cyc(3);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
        $display("tx reset: outputs idle");
    endtask

    task automatic test_no_clock();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int ticks = 0;
        int guard = 0;
        pulse_start(8'hA5);
        wait_request("no_clock");
        while (!error && guard < STO * 4) begin
            if (ce_7mp) ticks++;
            @(negedge clk_sys);
            guard++;
        end
        vectors++;
        if (ticks !== STO) begin
            miscompares++;
            $display("FAIL no_clock_timeout_ticks: got %0d expected %0d", ticks, STO);
        end
        vectors++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            miscompares++;
            $display("FAIL no_clock_oe_at_error: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
        end
        wait_not_busy("no_clock");
        vectors++;
        if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0) begin
            miscompares++;
            $display("FAIL no_clock_pulses: error %0d done %0d expected 1 and 0",
                     err_cnt - e0, done_cnt - d0);
        end
        $display("tx no_clock: error after %0d ticks", ticks);
    endtask

    task automatic test_xfer_timeout();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int guard = 0;
        logic [10:0] smp;
        pulse_start(8'h3C);
        wait_request("xfer_to");
        dev_frame(5, 1'b1, 0, 8'h00, smp);
        while (!error && guard < XTO * 4) begin
            @(negedge clk_sys);
            guard++;
        end
        vectors++;
        if (error !== 1'b1 || {ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            miscompares++;
            $display("FAIL xfer_timeout_error: error %b oe %b expected 1 and 00",
                     error, {ps2_clk_oe, ps2_data_oe});
        end
        wait_not_busy("xfer_to");
        vectors++;
        if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0) begin
            miscompares++;
            $display("FAIL xfer_timeout_pulses: error %0d done %0d expected 1 and 0",
                     err_cnt - e0, done_cnt - d0);
        end
        $display("tx xfer_timeout: stalled after 5 falls, error seen");
    endtask

    task automatic test_reset_midframe();
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic [10:0] smp;
        pulse_start(8'hF4);
        wait_request("mid_reset");
        dev_frame(4, 1'b1, 0, 8'h00, smp);
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        vectors++;
        if ({ps2_clk_oe, ps2_data_oe, busy, done, error} !== 5'b0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %b expected 00000",
                     {ps2_clk_oe, ps2_data_oe, busy, done, error});
        end
        cyc(30);
        vectors++;
        if ((err_cnt - e0) !== 0 || (done_cnt - d0) !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_quiet: error %0d done %0d busy %b expected 0 0 0",
                     err_cnt - e0, done_cnt - d0, busy);
        end
        $display("tx mid_reset: aborted after 4 falls");
        run_frame(8'hF4, 1'b1, 0, 1'b0, "after_reset");
    endtask

    initial begin
        logic [7:0] r;
        test_reset();
        run_frame(8'hF4, 1'b1, 0, 1'b0, "f4_ack");
        run_frame(8'hFF, 1'b1, 0, 1'b0, "ff_ack");
        run_frame(8'h00, 1'b1, 0, 1'b0, "00_ack");
        run_frame(8'hE6, 1'b0, 0, 1'b0, "nack");
        run_frame(8'h5A, 1'b1, 6, 1'b1, "start_while_busy");
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom);
            run_frame(r, 1'b1, 0, 1'b0, "random");
        end
        test_no_clock();
        test_xfer_timeout();
        test_reset_midframe();
        vectors++;
        if (both_cnt !== 0) begin
            miscompares++;
            $display("FAIL done_error_together: got %0d expected 0", both_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_TICKS, default 784, meaning clock-inhibit duration in ce_7mp ticks (112 us).
REQ-002 SHALL have parameter START_TIMEOUT, default 105000, meaning maximum ce_7mp ticks from request to the first device clock fall (15 ms).
REQ-003 SHALL have parameter XFER_TIMEOUT, default 14000, meaning maximum ce_7mp ticks from the first device clock fall to ACK (2 ms).
REQ-004 Port clk_sys  input  1  system clock; the sole clock.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port ce_7mp  input  1  7 MHz clock enable; it is the timebase for all timers.
REQ-007 Port ps2_mouse_clk  input  1  sensed PS/2 clock line (asynchronous).
REQ-008 Port ps2_mouse_data  input  1  sensed PS/2 data line (asynchronous).
REQ-009 Port ps2_clk_oe  output  1  1 = pull the clock line low; 0 = release it.
REQ-010 Port ps2_data_oe  output  1  1 = pull the data line low; 0 = release it.
REQ-011 Port tx_data  input  8  command byte; sampled when tx_start is accepted.
REQ-012 Port tx_start  input  1  single-cycle request to send tx_data.
REQ-013 Port busy  output  1  high from the accepted tx_start until the block returns to IDLE; the receiver gates frame capture with it.
REQ-014 Port done  output  1  single-cycle pulse when a frame completes with ACK.
REQ-015 Port error  output  1  single-cycle pulse on missing ACK or timeout.

Function
REQ-016 Both PS/2 inputs SHALL pass through a 2-FF synchronizer; falling-edge detection SHALL use the synchronized clock only.
REQ-017 The state machine SHALL have the states IDLE, INHIBIT, REQUEST, SHIFT, ACK and WAIT_IDLE.
REQ-018 In IDLE, tx_start SHALL latch tx_data, compute the odd-parity bit (~^tx_data), clear the timer, raise busy and go to INHIBIT; tx_start SHALL be ignored in every other state.
REQ-019 INHIBIT: ps2_clk_oe=1 and ps2_data_oe=0. After INHIBIT_TICKS ce_7mp ticks, set ps2_data_oe=1 (start bit); one clk_sys later set ps2_clk_oe=0, clear the timer and enter REQUEST.
REQ-020 REQUEST: on the first synchronized clock fall, drive data bit 0 (ps2_data_oe=~bit), set bit count to 1 and enter SHIFT; if the timer reaches START_TIMEOUT first, go to WAIT_IDLE and pulse error.
REQ-021 SHIFT: each subsequent clock fall SHALL drive the next bit, LSB first: bits 1-7, then parity, then released data (stop). The fall that releases data SHALL enter ACK.
REQ-022 ACK: on the next clock fall, sample the synchronized data line; low gives a done pulse and high gives an error pulse; either way go to WAIT_IDLE.
REQ-023 A single XFER_TIMEOUT timer SHALL run across SHIFT and ACK; expiry SHALL release both lines, pulse error and go to WAIT_IDLE.
REQ-024 WAIT_IDLE: both oe=0; when the clock and data lines are both synchronized high, go to IDLE and drop busy in the same cycle.
REQ-025 Exactly one of done and error SHALL pulse per accepted tx_start; they SHALL never pulse together.
REQ-026 Timers SHALL advance only on ce_7mp, SHALL be sized to hold START_TIMEOUT, and SHALL saturate at the limit.
REQ-027 A clock fall and a timer expiry in the same cycle: the expiry SHALL take priority.

Reset
REQ-028 Reset SHALL force IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, error=0, timers=0 and synchronizers=1, including in the middle of a frame; no error pulse SHALL be produced by that reset.

Structure
REQ-029 The ps2_pkg package SHALL hold the state enumeration and the three default timing constants, shared with the receive side.
REQ-030 The sub-module ps2_sync SHALL hold the 2-FF synchronizer and the falling-edge detector for the clock and data lines; nothing else is split out.

Verification
REQ-031 tx_data=0xF4 with a device model that ACKs -> clk_oe low for 784 ticks; data bits 0,0,1,0,1,1,1,1; parity 0; stop released; one done pulse; busy drops when the lines are high.
REQ-032 tx_data=0xFF with an ACK -> parity bit 1 on the 9th fall; done pulse.
REQ-033 Device clocks the frame but holds data high at ACK -> one error pulse, no done, return to IDLE.
REQ-034 Device never clocks -> error pulse exactly 105000 ce_7mp ticks after REQUEST entry; both oe=0.
REQ-035 tx_start while busy -> ignored; the frame in progress is unchanged and exactly one done pulse occurs.
REQ-036 Reset after the 4th clock fall -> next cycle both oe=0, busy=0, no pulses; a new tx_start of 0xF4 then completes normally.
